uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: synchronized UART receiver; start, DATA_SIZE data bits LSB first, even parity, stop.
// Define UART_RX_PARITY_CHECK_EN to check the parity bit; otherwise parity_err stays 0.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5,   // legal: >= 3
    parameter int DATA_SIZE    = 8    // legal: 1..10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [9:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]       IDX_LAST = 4'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    state_e           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [9:0]       shift_q, shift_d;
    logic [9:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_CHECK_EN
    logic             par_bit_q, par_bit_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_CHECK_EN
        par_bit_d    = par_bit_q;
`endif

        unique case (state_q)
            IDLE: begin
                // The detect cycle is the first cycle of the start bit, so the count
                // leaves here at 1 and CNT_HALF lands on the start-bit centre.
                if (!rxs_q) begin
                    state_d = START;
                end else begin
                    cnt_d = '0;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        shift_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
`ifdef UART_RX_PARITY_CHECK_EN
                    par_bit_d = rxs_q;
`endif
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    data_d      = shift_q;
                    valid_d     = 1'b1;
                    frame_err_d = !rxs_q;
`ifdef UART_RX_PARITY_CHECK_EN
                    parity_err_d = par_bit_q ^ (^shift_q);
`else
                    parity_err_d = 1'b0;
`endif
                    state_d = rxs_q ? IDLE : BREAK;
                end
            end

            BREAK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = state_d inside {DATA, PARITY, STOP, BREAK};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            par_bit_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so the synchronizer shifts one stage per clock and
            // every flop sees the pre-edge value of its neighbours.
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RX_PARITY_CHECK_EN
            par_bit_q    <= par_bit_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

    // A frame can never complete on two consecutive cycles.
    property p_valid_single;
        @(posedge clk) disable iff (!reset) valid_q |=> !valid_q;
    endproperty
    assert property (p_valid_single);

    property p_idle_not_busy;
        @(posedge clk) disable iff (!reset) (state_q == IDLE) |-> !busy_q;
    endproperty
    assert property (p_idle_not_busy);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a scoreboard of expected words, flags and latencies.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB     = 5;
    localparam int DS      = 8;
    localparam int LATENCY = 54;
`ifdef UART_RX_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [9:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_SIZE(DS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  data;
        logic        perr;
        logic        ferr;
        logic [31:0] start_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive rx for one clock, then look at the outputs 1 ns after the edge.
    task automatic tick(input logic v);
        exp_t e;
        rx = v;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            check("valid_one_cycle", 32'(prev_valid), 0);
            check("frame_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data", 32'(data), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
                check("latency", cyc - e.start_cyc, LATENCY);
            end
        end
        prev_valid = valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // Latency is counted from the first edge that samples the falling rx.
    task automatic expect_frame(input logic [9:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data      = d;
        e.perr      = perr;
        e.ferr      = ferr;
        e.start_cyc = 32'(cyc + 1);
        sb.push_back(e);
    endtask

    // glitch inverts the first cycle of every bit after the start bit, away from the centre sample.
    task automatic send_frame(input logic [9:0] d, input logic par_flip, input logic stop_bit,
                              input logic glitch);
        logic par;
        logic v;
        par = (^d[DS-1:0]) ^ par_flip;
        for (int b = 0; b < DS + 3; b++) begin
            if (b == 0)           v = 1'b0;
            else if (b <= DS)     v = d[b-1];
            else if (b == DS + 1) v = par;
            else                  v = stop_bit;
            for (int i = 0; i < CPB; i++) begin
                tick((glitch && b > 0 && i == 0) ? ~v : v);
            end
        end
    endtask

    initial begin
        int busy_seen;
        logic [9:0] partial;

        // Reset state.
        reset = 1'b0;
        idle(3);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        idle(4);

        // Clean frame 0xA5.
        expect_frame(10'h0A5, 1'b0, 1'b0);
        send_frame(10'h0A5, 1'b0, 1'b1, 1'b0);
        check("a5_busy_after", 32'(busy), 0);
        idle(10);
        check("a5_data_hold", 32'(data), 32'h0A5);

        // Wrong parity on 0x01.
        expect_frame(10'h001, PAR_EN, 1'b0);
        send_frame(10'h001, 1'b1, 1'b1, 1'b0);
        idle(6);
        check("p01_perr_hold", 32'(parity_err), 32'(PAR_EN));

        // Stop bit low on 0x3C, line held low into a break.
        expect_frame(10'h03C, 1'b0, 1'b1);
        send_frame(10'h03C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (i == 10) check("break_busy", 32'(busy), 1);
        end
        tick(1'b1);
        check("break_busy_until_rxs", 32'(busy), 1);
        idle(4);
        check("break_exit_busy", 32'(busy), 0);
        idle(60);
        check("break_ferr_hold", 32'(frame_err), 1);

        // One-cycle low glitch on an idle line.
        busy_seen = 0;
        tick(1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (busy) busy_seen++;
        end
        check("glitch_busy", 32'(busy_seen), 0);
        check("glitch_data_hold", 32'(data), 32'h03C);

        // Back-to-back frames, second with mid-bit glitches.
        expect_frame(10'h055, 1'b0, 1'b0);
        send_frame(10'h055, 1'b0, 1'b1, 1'b0);
        expect_frame(10'h0AA, 1'b0, 1'b0);
        send_frame(10'h0AA, 1'b0, 1'b1, 1'b1);
        idle(8);

        // Reset during data bit 4 of an abandoned frame.
        partial = 10'h05A;
        for (int i = 0; i < CPB; i++) tick(1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < CPB; i++) tick(partial[b]);
        end
        tick(partial[4]);
        tick(partial[4]);
        check("pre_reset_busy", 32'(busy), 1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick(partial[4]);
        check("midrst_data", 32'(data), 0);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_frame_err", 32'(frame_err), 0);
        check("midrst_busy", 32'(busy), 0);
        reset = 1'b1;
        idle(60);
        check("post_reset_busy", 32'(busy), 0);

        // Full frame after reset.
        expect_frame(10'h07E, 1'b0, 1'b0);
        send_frame(10'h07E, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("all_frames_seen", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
